// File: rtl/sketch_pkg.sv
// Shared definitions for the etch-a-sketch drawing datapath.
//   - Display geometry and VRAM size constants
//   - color_t (RGB332 pixel), coordinate and VRAM address types
//   - painter_state_t: touch_painter FSM states
//   - row_offset(): y * width using shifts and adds instead of a multiplier
package sketch_pkg;

    localparam int DISPLAY_WIDTH  = 240;
    localparam int DISPLAY_HEIGHT = 320;
    localparam int VRAM_LENGTH    = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int COORD_W        = 9;
    localparam int ADDR_W         = $clog2(VRAM_LENGTH);

    typedef logic [7:0]         color_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ADDR_W-1:0]  vaddr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PAINT,
        S_CLEAR
    } painter_state_t;

    // The native panel width gets the cheap 256-16 form; any other width
    // falls back to a shift-and-add over the set bits of the constant.
    function automatic vaddr_t row_offset(input coord_t y, input int unsigned width);
        vaddr_t yw;
        vaddr_t acc;
        yw  = vaddr_t'(y);
        acc = '0;
        if (width == 240) begin
            acc = (yw << 8) - (yw << 4);
        end else begin
            for (int i = 0; i < COORD_W; i++) begin
                if (width[i]) acc = acc + (yw << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/touch_painter_if.sv
// Bus between the touch front end, the painter and the VRAM write port.
//   touch_valid/touch_ready/touch_x/touch_y/color : touch point handshake
//   clear_req                                     : single-cycle clear request
//   busy                                          : painter not idle
//   vram_wr_ena/vram_wr_addr/vram_wr_data         : VRAM write port
// slave = the painter, master = whoever drives touches and sinks writes.
interface touch_painter_if;
    import sketch_pkg::*;

    logic   touch_valid;
    logic   touch_ready;
    coord_t touch_x;
    coord_t touch_y;
    color_t color;
    logic   clear_req;
    logic   busy;
    logic   vram_wr_ena;
    vaddr_t vram_wr_addr;
    color_t vram_wr_data;

    modport master (
        output touch_valid, touch_x, touch_y, color, clear_req,
        input  touch_ready, busy, vram_wr_ena, vram_wr_addr, vram_wr_data
    );

    modport slave (
        input  touch_valid, touch_x, touch_y, color, clear_req,
        output touch_ready, busy, vram_wr_ena, vram_wr_addr, vram_wr_data
    );

endinterface

// File: rtl/rect_scanner.sv
// Walks an inclusive rectangle row by row, one pixel per cycle.
//   start            : load x0..x1 / y0..y1 / row_base, first pixel next cycle
//   addr/valid/last  : current pixel address, pixel strobe, final pixel flag
// ROW_STRIDE is the VRAM row pitch added to the row base at each row end.
module rect_scanner import sketch_pkg::*; #(
    parameter int ROW_STRIDE = 240
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  coord_t x0,
    input  coord_t x1,
    input  coord_t y0,
    input  coord_t y1,
    input  vaddr_t row_base,
    output vaddr_t addr,
    output logic   valid,
    output logic   last
);

    localparam vaddr_t STRIDE = vaddr_t'(ROW_STRIDE);

    coord_t x_q, x_d, y_q, y_d;
    coord_t x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    vaddr_t base_q, base_d, addr_q, addr_d;
    logic   valid_q, valid_d;
    logic   at_row_end, at_last;

    assign at_row_end = (x_q == x1_q);
    assign at_last    = valid_q & at_row_end & (y_q == y1_q);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        base_d  = base_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (start) begin
            x_d     = x0;
            y_d     = y0;
            x0_d    = x0;
            x1_d    = x1;
            y1_d    = y1;
            base_d  = row_base;
            addr_d  = row_base + vaddr_t'(x0);
            valid_d = 1'b1;
        end else if (valid_q) begin
            if (at_last) begin
                valid_d = 1'b0;
            end else if (at_row_end) begin
                x_d    = x0_q;
                y_d    = y_q + 1'b1;
                base_d = base_q + STRIDE;
                addr_d = base_q + STRIDE + vaddr_t'(x0_q);
            end else begin
                x_d    = x_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign addr  = addr_q;
    assign valid = valid_q;
    assign last  = at_last;

endmodule

// File: rtl/touch_painter.sv
// Drawing stage: turns accepted touch points into a clipped square brush of
// VRAM writes and performs full-screen clears (on request and after reset).
//   clk, rst (async, active-low)
//   bus (slave): touch handshake, clear_req, busy, VRAM write port
module touch_painter #(
    parameter int         DISPLAY_WIDTH  = sketch_pkg::DISPLAY_WIDTH,
    parameter int         DISPLAY_HEIGHT = sketch_pkg::DISPLAY_HEIGHT,
    parameter int         BRUSH_RADIUS   = 1,
    parameter logic [7:0] BG_COLOR       = 8'h00,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input logic            clk,
    input logic            rst,
    touch_painter_if.slave bus
);
    import sketch_pkg::*;

    localparam logic signed [9:0] RAD    = 10'(BRUSH_RADIUS);
    localparam logic signed [9:0] X_MAXS = 10'(DISPLAY_WIDTH - 1);
    localparam logic signed [9:0] Y_MAXS = 10'(DISPLAY_HEIGHT - 1);
    localparam coord_t            X_LAST = coord_t'(DISPLAY_WIDTH - 1);
    localparam coord_t            Y_LAST = coord_t'(DISPLAY_HEIGHT - 1);

    painter_state_t state_q, state_d;
    logic   pending_q, pending_d;
    logic   init_done_q, init_done_d;
    logic   ready_q, ready_d;
    logic   busy_q, busy_d;
    coord_t x_q, x_d, y_q, y_d;
    color_t color_q, color_d;
    color_t data_q, data_d;

    // Brush clipping; 10-bit signed so x-R below zero shows up as negative.
    logic signed [9:0] xs_lo, xs_hi, ys_lo, ys_hi;
    coord_t cx0, cx1, cy0, cy1;
    logic   out_of_range;

    assign xs_lo = $signed({1'b0, x_q}) - RAD;
    assign xs_hi = $signed({1'b0, x_q}) + RAD;
    assign ys_lo = $signed({1'b0, y_q}) - RAD;
    assign ys_hi = $signed({1'b0, y_q}) + RAD;

    always_comb begin
        cx0 = (xs_lo < 10'sd0)  ? '0     : xs_lo[8:0];
        cx1 = (xs_hi > X_MAXS)  ? X_LAST : xs_hi[8:0];
        cy0 = (ys_lo < 10'sd0)  ? '0     : ys_lo[8:0];
        cy1 = (ys_hi > Y_MAXS)  ? Y_LAST : ys_hi[8:0];
    end

    assign out_of_range = (x_q >= coord_t'(DISPLAY_WIDTH)) | (y_q >= coord_t'(DISPLAY_HEIGHT));

    // The scanner serves both jobs: a clear is just the full-screen rectangle.
    logic   scan_start, scan_clear;
    coord_t sx0, sx1, sy0, sy1;
    vaddr_t sbase, scan_addr;
    logic   scan_valid, scan_last;

    assign sx0   = scan_clear ? '0     : cx0;
    assign sx1   = scan_clear ? X_LAST : cx1;
    assign sy0   = scan_clear ? '0     : cy0;
    assign sy1   = scan_clear ? Y_LAST : cy1;
    assign sbase = scan_clear ? '0     : row_offset(cy0, DISPLAY_WIDTH);

    rect_scanner #(.ROW_STRIDE(DISPLAY_WIDTH)) u_scan (
        .clk      (clk),
        .rst      (rst),
        .start    (scan_start),
        .x0       (sx0),
        .x1       (sx1),
        .y0       (sy0),
        .y1       (sy1),
        .row_base (sbase),
        .addr     (scan_addr),
        .valid    (scan_valid),
        .last     (scan_last)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        init_done_d = 1'b1;
        x_d         = x_q;
        y_d         = y_q;
        color_d     = color_q;
        data_d      = data_q;
        scan_start  = 1'b0;
        scan_clear  = 1'b0;

        // init_done_q is low only in the first cycle after reset release.
        if ((bus.clear_req && state_q != S_CLEAR) || (CLEAR_ON_RESET && !init_done_q))
            pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d    = S_CLEAR;
                    pending_d  = 1'b0;
                    scan_start = 1'b1;
                    scan_clear = 1'b1;
                    data_d     = BG_COLOR;
                end else if (bus.touch_valid && ready_q) begin
                    x_d     = bus.touch_x;
                    y_d     = bus.touch_y;
                    color_d = bus.color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (out_of_range) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_PAINT;
                    scan_start = 1'b1;
                    data_d     = color_q;
                end
            end
            S_PAINT, S_CLEAR: begin
                if (scan_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from next-state values so both read 0 while in reset.
        ready_d = (state_d == S_IDLE) && !pending_d;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            init_done_q <= init_done_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            data_q      <= data_d;
        end
    end

    assign bus.touch_ready  = ready_q;
    assign bus.busy         = busy_q;
    assign bus.vram_wr_ena  = scan_valid;
    assign bus.vram_wr_addr = scan_addr;
    assign bus.vram_wr_data = data_q;

endmodule

// File: tb/tb_touch_painter.sv
// Bench for touch_painter: a full-size 240x320 instance (no clear on reset)
// and a small 16x12 instance (clear on reset, non-zero background).
// Expected VRAM writes are queued when stimulus is driven and popped by a
// per-instance monitor whenever a write strobe is seen.
module tb_touch_painter;
    import sketch_pkg::*;

    localparam int         AW   = 240;
    localparam int         AH   = 320;
    localparam int         BW   = 16;
    localparam int         BH   = 12;
    localparam int         R    = 1;
    localparam logic [7:0] B_BG = 8'h5A;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    touch_painter_if bus_a ();
    touch_painter_if bus_b ();

    touch_painter #(
        .DISPLAY_WIDTH(AW), .DISPLAY_HEIGHT(AH), .BRUSH_RADIUS(R),
        .BG_COLOR(8'h00), .CLEAR_ON_RESET(1'b0)
    ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

    touch_painter #(
        .DISPLAY_WIDTH(BW), .DISPLAY_HEIGHT(BH), .BRUSH_RADIUS(R),
        .BG_COLOR(B_BG), .CLEAR_ON_RESET(1'b1)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    int errors = 0;
    int checks = 0;
    logic [24:0] q_a[$];
    logic [24:0] q_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference brush model: plain integer clipping and y*W+x addressing.
    function automatic void push_rect(input bit to_b, input int x, input int y, input logic [7:0] c);
        int w, h, x0, x1, y0, y1;
        logic [24:0] e;
        w = to_b ? BW : AW;
        h = to_b ? BH : AH;
        if (x >= w || y >= h) return;
        x0 = (x - R < 0) ? 0 : x - R;
        x1 = (x + R > w - 1) ? w - 1 : x + R;
        y0 = (y - R < 0) ? 0 : y - R;
        y1 = (y + R > h - 1) ? h - 1 : y + R;
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx++) begin
                e = {17'(yy * w + xx), c};
                if (to_b) q_b.push_back(e); else q_a.push_back(e);
            end
        end
    endfunction

    function automatic void push_clear(input bit to_b, input logic [7:0] bg);
        int n;
        n = to_b ? BW * BH : AW * AH;
        for (int a = 0; a < n; a++) begin
            if (to_b) q_b.push_back({17'(a), bg}); else q_a.push_back({17'(a), bg});
        end
    endfunction

    always @(negedge clk) begin : mon_a
        logic [24:0] e;
        if (bus_a.vram_wr_ena === 1'b1) begin
            check("a_write_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_write", {7'b0, bus_a.vram_wr_addr, bus_a.vram_wr_data}, {7'b0, e});
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [24:0] e;
        if (bus_b.vram_wr_ena === 1'b1) begin
            check("b_write_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b_write", {7'b0, bus_b.vram_wr_addr, bus_b.vram_wr_data}, {7'b0, e});
            end
        end
    end

    function automatic logic get_ready(input bit to_b);
        return to_b ? bus_b.touch_ready : bus_a.touch_ready;
    endfunction

    function automatic logic get_busy(input bit to_b);
        return to_b ? bus_b.busy : bus_a.busy;
    endfunction

    function automatic logic get_ena(input bit to_b);
        return to_b ? bus_b.vram_wr_ena : bus_a.vram_wr_ena;
    endfunction

    function automatic int q_size(input bit to_b);
        return to_b ? q_b.size() : q_a.size();
    endfunction

    task automatic set_touch(input bit to_b, input logic v, input int x, input int y, input logic [7:0] c);
        if (to_b) begin
            bus_b.touch_valid = v; bus_b.touch_x = 9'(x); bus_b.touch_y = 9'(y); bus_b.color = c;
        end else begin
            bus_a.touch_valid = v; bus_a.touch_x = 9'(x); bus_a.touch_y = 9'(y); bus_a.color = c;
        end
    endtask

    // Waits (bounded) for ready, presents one point for one accepting edge.
    task automatic touch(input bit to_b, input int x, input int y, input logic [7:0] c);
        int n;
        n = 0;
        while (get_ready(to_b) !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        check(to_b ? "b_ready_wait" : "a_ready_wait", 32'(get_ready(to_b)), 32'd1);
        set_touch(to_b, 1'b1, x, y, c);
        push_rect(to_b, x, y, c);
        @(posedge clk);
        #1 set_touch(to_b, 1'b0, 0, 0, 8'h00);
    endtask

    task automatic wait_idle(input bit to_b, input int budget, input string tag);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end
        while ((get_busy(to_b) !== 1'b0 || q_size(to_b) != 0) && n < budget);
        check({tag, "_drained"}, 32'(q_size(to_b)), 32'd0);
        check({tag, "_busy"}, 32'(get_busy(to_b)), 32'd0);
        check({tag, "_ready"}, 32'(get_ready(to_b)), 32'd1);
    endtask

    task automatic reset_mid_paint(input bit to_b, input int x, input int y, input logic [7:0] c);
        int n;
        touch(to_b, x, y, c);
        n = 0;
        while (get_ena(to_b) !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        if (to_b) rst_b = 1'b0; else rst_a = 1'b0;
        #1;
        check(to_b ? "b_rst_ena" : "a_rst_ena", 32'(get_ena(to_b)), 32'd0);
        check(to_b ? "b_rst_busy" : "a_rst_busy", 32'(get_busy(to_b)), 32'd0);
        check(to_b ? "b_rst_ready" : "a_rst_ready", 32'(get_ready(to_b)), 32'd0);
        if (to_b) q_b.delete(); else q_a.delete();
        @(negedge clk);
    endtask

    initial begin
        int n;
        set_touch(1'b0, 1'b0, 0, 0, 8'h00);
        set_touch(1'b1, 1'b0, 0, 0, 8'h00);
        bus_a.clear_req = 1'b0;
        bus_b.clear_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("a_rst_ready", 32'(bus_a.touch_ready), 32'd0);
        check("a_rst_busy", 32'(bus_a.busy), 32'd0);
        check("a_rst_ena", 32'(bus_a.vram_wr_ena), 32'd0);
        check("a_rst_addr", 32'(bus_a.vram_wr_addr), 32'd0);
        check("a_rst_data", 32'(bus_a.vram_wr_data), 32'd0);
        check("b_rst_ready", 32'(bus_b.touch_ready), 32'd0);
        check("b_rst_busy", 32'(bus_b.busy), 32'd0);

        // Release: A idles ready, B clears the whole (small) screen first
        push_clear(1'b1, B_BG);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("a_ready_after_release", 32'(bus_a.touch_ready), 32'd1);
        check("b_pending_ready", 32'(bus_b.touch_ready), 32'd0);
        check("b_pending_busy", 32'(bus_b.busy), 32'd0);
        check("b_pending_ena", 32'(bus_b.vram_wr_ena), 32'd0);
        @(negedge clk);
        check("b_clear_busy", 32'(bus_b.busy), 32'd1);
        check("b_clear_ena", 32'(bus_b.vram_wr_ena), 32'd1);
        wait_idle(1'b1, 400, "b_reset_clear");

        // Centre touch with latency checks
        touch(1'b0, 100, 50, 8'hE0);
        check("a_setup_busy", 32'(bus_a.busy), 32'd1);
        check("a_setup_ena", 32'(bus_a.vram_wr_ena), 32'd0);
        check("a_setup_ready", 32'(bus_a.touch_ready), 32'd0);
        @(posedge clk);
        #1 check("a_first_write", 32'(bus_a.vram_wr_ena), 32'd1);
        wait_idle(1'b0, 50, "a_centre");

        // Corners
        touch(1'b0, 0, 0, 8'h1C);
        wait_idle(1'b0, 50, "a_corner_lo");
        touch(1'b0, 239, 319, 8'h03);
        wait_idle(1'b0, 50, "a_corner_hi");

        // Out-of-range point: accepted, dropped
        touch(1'b0, 240, 10, 8'hFF);
        check("a_oor_busy", 32'(bus_a.busy), 32'd1);
        @(posedge clk);
        #1;
        check("a_oor_ready", 32'(bus_a.touch_ready), 32'd1);
        check("a_oor_idle", 32'(bus_a.busy), 32'd0);
        check("a_oor_ena", 32'(bus_a.vram_wr_ena), 32'd0);

        // clear_req with a touch on the same edge; second point held through clear
        @(negedge clk);
        set_touch(1'b0, 1'b1, 120, 160, 8'hC3);
        bus_a.clear_req = 1'b1;
        push_rect(1'b0, 120, 160, 8'hC3);
        push_clear(1'b0, 8'h00);
        push_rect(1'b0, 10, 20, 8'h7F);
        @(posedge clk);
        #1;
        bus_a.clear_req = 1'b0;
        set_touch(1'b0, 1'b1, 10, 20, 8'h7F);
        repeat (100) @(negedge clk);
        check("a_clear_blocks_ready", 32'(bus_a.touch_ready), 32'd0);
        check("a_clear_busy", 32'(bus_a.busy), 32'd1);
        n = 0;
        while (bus_a.touch_ready !== 1'b1 && n < 90000) begin @(negedge clk); n++; end
        check("a_ready_after_clear", 32'(bus_a.touch_ready), 32'd1);
        check("a_clear_fully_drained", 32'(q_a.size()), 32'd9);
        @(posedge clk);
        #1 set_touch(1'b0, 1'b0, 0, 0, 8'h00);
        wait_idle(1'b0, 50, "a_held_touch");

        // Reset in the middle of a paint, then normal operation
        reset_mid_paint(1'b0, 50, 60, 8'hAA);
        rst_a = 1'b1;
        touch(1'b0, 200, 300, 8'h55);
        wait_idle(1'b0, 50, "a_after_reset");

        // Small instance: generic row-offset path, bottom-edge clipping
        touch(1'b1, 5, 11, 8'h99);
        wait_idle(1'b1, 50, "b_bottom");
        reset_mid_paint(1'b1, 7, 7, 8'h21);
        push_clear(1'b1, B_BG);
        rst_b = 1'b1;
        wait_idle(1'b1, 400, "b_reclear");
        touch(1'b1, 0, 0, 8'h42);
        wait_idle(1'b1, 50, "b_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/touch_painter.md
# touch_painter

Drawing stage of the etch-a-sketch datapath. Consumes touch coordinates from the FT6206 touch controller front end via a valid/ready handshake. Rasterises a clipped square brush around each point into VRAM writes, one pixel per cycle. Also performs full-screen clears, on request and optionally after reset. Its write port feeds the VRAM that the ILI9341 display driver scans out.

## Interface

**Parameters**
- `DISPLAY_WIDTH`, default 240: pixels per row.
- `DISPLAY_HEIGHT`, default 320: rows.
- `BRUSH_RADIUS`, default 1: brush is a square of side 2·R+1.
- `BG_COLOR`, default 8'h00: clear colour.
- `CLEAR_ON_RESET`, default 1: clear the whole screen after reset deasserts.

**Ports**
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `touch_valid`, in, 1: touch point available.
- `touch_ready`, out, 1: point accepted when `touch_valid & touch_ready` at a rising edge.
- `touch_x`, in, 9: column, 0..DISPLAY_WIDTH-1 when valid.
- `touch_y`, in, 9: row, 0..DISPLAY_HEIGHT-1 when valid.
- `color`, in, 8: RGB332 brush colour, sampled at accept.
- `clear_req`, in, 1: single-cycle clear request.
- `busy`, out, 1: high in any state other than IDLE.
- `vram_wr_ena`, out, 1: write strobe. VRAM accepts one write every cycle, with no backpressure.
- `vram_wr_addr`, out, 17: address = y·DISPLAY_WIDTH + x.
- `vram_wr_data`, out, 8: pixel colour.

## Operation
- FSM states: `S_IDLE`, `S_SETUP`, `S_PAINT`, `S_CLEAR`.
- `clear_pending` register:
  - Set by `clear_req` in any state except S_CLEAR; `clear_req` seen during S_CLEAR is ignored.
  - Set on reset release when CLEAR_ON_RESET=1.
  - Cleared on entry to S_CLEAR.
- `touch_ready = (state == S_IDLE) & ~clear_pending`.
- S_IDLE transitions:
  - If `clear_pending`, go to S_CLEAR.
  - Else on a touch handshake, latch x, y and color, then go to S_SETUP.
- S_SETUP (one cycle):
  - Compute x0 = max(x−R, 0), x1 = min(x+R, W−1), y0 = max(y−R, 0), y1 = min(y+R, H−1).
  - Compute row base = y0·W using shift/subtract (240 = 256−16); no multiplier.
  - If x ≥ W or y ≥ H, the point is dropped: return to S_IDLE with no writes.
  - Otherwise go to S_PAINT.
- S_PAINT:
  - Scan rows y0..y1, and within each row columns x0..x1, writing `color`.
  - Address is incremented; at end of row, row base += W.
  - Return to S_IDLE after the last pixel.
- S_CLEAR: scan addresses 0..W·H−1 (76 800 writes) with `BG_COLOR`, then return to S_IDLE.
- Simultaneous `clear_req` and touch handshake in the same IDLE cycle: the touch is accepted and painted, then the clear runs.
- Address arithmetic is 17-bit unsigned; coordinate clipping uses 10-bit signed intermediates so that x−R below zero is detected.

## Timing
- Reset values while `rst` is low:
  - state = S_IDLE
  - all outputs 0, including `touch_ready`
  - `clear_pending` = 0
- First cycle after reset release: with CLEAR_ON_RESET=1, `clear_pending` is set and state enters S_CLEAR on the following edge.
- Reset asserted mid-operation forces all outputs to 0 immediately (asynchronous). The in-progress operation is abandoned.
- Touch latency:
  - Handshake at edge E; S_SETUP during cycle E..E+1.
  - First `vram_wr_ena` high in the cycle after edge E+1.
  - Writes continue on consecutive cycles: (x1−x0+1)·(y1−y0+1) of them.
  - `touch_ready` is high the cycle after the last write.
- Clear: `vram_wr_ena` high for exactly W·H consecutive cycles, starting the cycle after S_CLEAR is entered.
- Writes are gap-free within an operation. `busy` is registered and equals state ≠ S_IDLE.

## Structure
- Package `sketch_pkg` holds:
  - DISPLAY_WIDTH, DISPLAY_HEIGHT and VRAM_LENGTH constants
  - the `color_t` (8-bit RGB332) typedef
  - the `painter_state_t` enum
- Sub-module `rect_scanner` walks an inclusive rectangle (x0, x1, y0, y1, row base) and emits address, valid and last. It is reused for both paint and clear; a clear is the rectangle 0..W−1 × 0..H−1.

## Test plan
- Reset release, CLEAR_ON_RESET=1 → 76 800 consecutive writes, addresses 0..76 799, data 8'h00. `busy` then falls and `touch_ready` rises.
- Touch (100, 50), color 8'hE0, R=1 → 9 writes with data E0, in order:
  - 11 859, 11 860, 11 861
  - 12 099, 12 100, 12 101
  - 12 339, 12 340, 12 341
- Corner touch (0, 0) → 4 writes: 0, 1, 240, 241. Touch (239, 319) → 4 writes: 76 558, 76 559, 76 798, 76 799.
- Out-of-range touch (240, 10) → accepted, zero writes, `touch_ready` high 2 cycles after the handshake.
- `clear_req` and touch handshake on the same edge → the 9 paint writes, then 76 800 clear writes. A `touch_valid` held during the clear is not accepted until the clear finishes.
- `rst` low during S_PAINT → `vram_wr_ena` and `busy` drop in the same cycle. After release the block re-clears (if enabled) and then accepts a new touch normally.
